// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the FIPS 180-4 logical functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal
  } state_e;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next,
  output logic [31:0] f_next,
  output logic [31:0] g_next,
  output logic [31:0] h_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Round function: two temporaries, then rotate the working variables.
  always_comb begin
    t1     = h + big_sigma1(e) + ch(e, f, g) + k + w;
    t2     = big_sigma0(a) + maj(a, b, c);
    a_next = t1 + t2;
    b_next = a;
    c_next = b;
    d_next = c;
    e_next = d + t1;
    f_next = e;
    g_next = f;
    h_next = g;
  end

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 block compressor: IDLE -> ROUND (64/R edges) -> FINAL, R rounds per clock.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         first_block,
  input  logic [511:0] msg_block,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);

  localparam logic [6:0] RoundStep = 7'(ROUNDS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [6:0]   round_q, round_d;
  logic         done_q, done_d;
  logic [255:0] digest_q, digest_d;
  logic [255:0] work_q, work_d;
  logic [255:0] chain_q, chain_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [31:0]  w_next [16];
  logic [255:0] round_out;

  // Chain of round instances; stage gi uses K[t+gi] and window word gi (= W[t+gi]).
  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    logic [255:0] in_s;
    logic [255:0] out_s;
    if (gi == 0) begin : g_head
      assign in_s = work_q;
    end else begin : g_tail
      assign in_s = g_round[gi-1].out_s;
    end
    sha256_round u_round (
      .a      (in_s[255:224]),
      .b      (in_s[223:192]),
      .c      (in_s[191:160]),
      .d      (in_s[159:128]),
      .e      (in_s[127:96]),
      .f      (in_s[95:64]),
      .g      (in_s[63:32]),
      .h      (in_s[31:0]),
      .k      (K[round_q[5:0] + 6'(gi)]),
      .w      (w_q[gi]),
      .a_next (out_s[255:224]),
      .b_next (out_s[223:192]),
      .c_next (out_s[191:160]),
      .d_next (out_s[159:128]),
      .e_next (out_s[127:96]),
      .f_next (out_s[95:64]),
      .g_next (out_s[63:32]),
      .h_next (out_s[31:0])
    );
  end

  assign round_out = g_round[ROUNDS_PER_CYCLE-1].out_s;

  // Message schedule: extend the window by R words and shift it down by R.
  always_comb begin
    logic [31:0] ext [20];
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int i = 16; i < 20; i++) ext[i] = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end
    for (int i = 0; i < 16; i++) w_next[i] = ext[i+ROUNDS_PER_CYCLE];
  end

  // FSM next state and datapath next values.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    done_d   = 1'b0;
    digest_d = digest_q;
    work_d   = work_q;
    chain_d  = chain_q;
    w_d      = w_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = first_block ? IV : digest_q;
          chain_d = first_block ? IV : digest_q;
          for (int i = 0; i < 16; i++) w_d[i] = msg_block[511-32*i -: 32];
          round_d = '0;
          state_d = StRound;
        end
      end
      StRound: begin
        work_d  = round_out;
        w_d     = w_next;
        round_d = round_q + RoundStep;
        if (round_d == 7'd64) state_d = StFinal;
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) begin
          digest_d[32*i +: 32] = chain_q[32*i +: 32] + work_q[32*i +: 32];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and digest, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      round_q  <= '0;
      done_q   <= 1'b0;
      digest_q <= IV;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      done_q   <= done_d;
      digest_q <= digest_d;
    end
  end

  // Working variables, latched chaining value and W window carry no reset.
  always_ff @(posedge clk) begin
    work_q  <= work_d;
    chain_q <= chain_d;
    w_q     <= w_d;
  end

  assign ready  = (state_q == StIdle);
  assign done   = done_q;
  assign digest = digest_q;

endmodule

// File: tb/tb_sha256_block_engine.sv
// Bench: three engines (R=1,2,4), directed FIPS vectors, queue scoreboard on done.
module tb_sha256_block_engine;

  localparam logic [255:0] HIv  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] HAbc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] HEmpty =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] HTwo =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] MAbc   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] MEmpty = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] MTwo1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MTwo2  = {{15{32'h0}}, 32'h000001c0};

  typedef struct {
    logic         chk;
    logic [255:0] val;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start [3];
  logic         first [3];
  logic [511:0] msg [3];
  logic         ready [3];
  logic         done [3];
  logic [255:0] digest [3];

  exp_t exp_q [3][$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_lat [3] = '{65, 33, 17};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sha256_block_engine #(
      .ROUNDS_PER_CYCLE (1 << gi)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start[gi]),
      .first_block (first[gi]),
      .msg_block   (msg[gi]),
      .ready       (ready[gi]),
      .done        (done[gi]),
      .digest      (digest[gi])
    );
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready, present one block for one edge, optionally enqueue the expected digest.
  task automatic issue(input int k, input logic fb, input logic [511:0] m, input logic push,
                       input logic chk, input logic [255:0] ev);
    int n = 0;
    while (ready[k] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check($sformatf("ready_before_issue_dut%0d", k), 256'(ready[k]), 256'd1);
    start[k] = 1'b1;
    first[k] = fb;
    msg[k]   = m;
    if (push) exp_q[k].push_back('{chk, ev});
    tick();
    start[k] = 1'b0;
    first[k] = ~fb;
    msg[k]   = {16{$urandom()}};
  endtask

  // Count edges from the accept edge until done; optional mid-block start pulse.
  task automatic wait_done(input int k, input int pulse_at, output int edges,
                           output logic ready_bad);
    edges     = 0;
    ready_bad = 1'b0;
    while (done[k] !== 1'b1 && edges < 200) begin
      if (edges == pulse_at) begin
        start[k] = 1'b1;
        first[k] = 1'b0;
        msg[k]   = {16{$urandom()}};
      end else begin
        start[k] = 1'b0;
      end
      tick();
      edges++;
      if (done[k] !== 1'b1 && ready[k] !== 1'b0) ready_bad = 1'b1;
    end
    start[k] = 1'b0;
    if (done[k] !== 1'b1) check($sformatf("done_timeout_dut%0d", k), 256'd0, 256'd1);
  endtask

  initial begin
    int   lat;
    logic rbad;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      first[k] = 1'b0;
      msg[k]   = '0;
    end

    // Scoreboard monitor: every done pops one expected digest.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (done[k] === 1'b1) begin
            if (exp_q[k].size() == 0) begin
              check($sformatf("unexpected_done_dut%0d", k), 256'd1, 256'd0);
            end else begin
              e = exp_q[k].pop_front();
              if (e.chk) check($sformatf("digest_dut%0d", k), digest[k], e.val);
            end
          end
        end
      end
    join_none

    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready_dut%0d", k), 256'(ready[k]), 256'd1);
      check($sformatf("reset_done_dut%0d", k), 256'(done[k]), 256'd0);
      check($sformatf("reset_digest_dut%0d", k), digest[k], HIv);
    end
    rst = 1'b0;
    tick();

    // abc, then empty message accepted in the done cycle, then the two-block message.
    issue(0, 1'b1, MAbc, 1'b1, 1'b1, HAbc);
    wait_done(0, -1, lat, rbad);
    check("latency_abc", 256'(lat), 256'd65);
    issue(0, 1'b1, MEmpty, 1'b1, 1'b1, HEmpty);
    wait_done(0, -1, lat, rbad);
    check("latency_back_to_back", 256'(lat), 256'd65);
    issue(0, 1'b1, MTwo1, 1'b1, 1'b0, '0);
    wait_done(0, -1, lat, rbad);
    check("ready_in_done_cycle", 256'(ready[0]), 256'd1);
    issue(0, 1'b0, MTwo2, 1'b1, 1'b1, HTwo);
    wait_done(0, -1, lat, rbad);
    tick();

    // Latency, ready low, ignored mid-block starts and digest hold for each R.
    for (int k = 0; k < 3; k++) begin
      issue(k, 1'b1, MAbc, 1'b1, 1'b1, HAbc);
      wait_done(k, 3, lat, rbad);
      check($sformatf("latency_dut%0d", k), 256'(lat), 256'(exp_lat[k]));
      check($sformatf("ready_low_dut%0d", k), 256'(rbad), 256'd0);
      repeat (3) tick();
      check($sformatf("digest_hold_dut%0d", k), digest[k], HAbc);
    end

    // Abort at round 30, then a clean abc block.
    issue(0, 1'b1, MAbc, 1'b0, 1'b0, '0);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 256'(ready[0]), 256'd1);
    check("abort_done", 256'(done[0]), 256'd0);
    check("abort_digest", digest[0], HIv);
    repeat (80) tick();
    issue(0, 1'b1, MAbc, 1'b1, 1'b1, HAbc);
    wait_done(0, -1, lat, rbad);
    check("latency_after_abort", 256'(lat), 256'd65);
    repeat (3) tick();

    for (int k = 0; k < 3; k++) begin
      check($sformatf("pending_expected_dut%0d", k), 256'(exp_q[k].size()), 256'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
